// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//
// Holds the architectural NZCV flag register and resolves ID-stage branches
// (B.cond, CBZ, CBNZ, B) for a 5-stage pipeline. The unit sits between the
// EX-stage ALU flag outputs and the ID-stage PC-select logic.
//
// A B.cond in ID can depend on a flag write that is still in EX. In that case
// the unit does one of two things:
//   BYPASS=1 : the branch sees the live EX flags in the same cycle.
//   BYPASS=0 : stall_o holds ID/IF for one cycle. The branch is then resolved
//              from the freshly written flags_q.
//
// Parameters
//   BYPASS    1 = forward EX flags to the ID branch, 0 = stall one cycle
//   AL_TAKEN  1 = condition 1111 is taken, 0 = condition 1111 is never taken
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   ex_valid       EX stage holds a live instruction
//   ex_set_flags   EX instruction writes NZCV
//   ex_zero        ALU Zero
//   ex_negative    ALU Negative
//   ex_overflow    ALU Overflow
//   ex_carry       ALU CarryOut
//   pipe_stall     external pipeline freeze; holds all state
//   flush          kill the instruction in ID
//   br_valid       ID holds a branch
//   br_kind        00 B.cond, 01 CBZ, 10 CBNZ, 11 B
//   br_cond        condition code (B.cond only)
//   br_reg_zero    tested register equals zero (CBZ/CBNZ)
//   flags_q        architectural flags {N,Z,C,V}
//   stall_o        flag-hazard hold request to ID/IF (combinational)
//   br_resolved_q  one-cycle pulse: a branch was resolved
//   br_taken_q     branch decision, valid while br_resolved_q=1
// -----------------------------------------------------------------------------
module flag_branch_unit #(
  parameter bit BYPASS   = 1'b1,
  parameter bit AL_TAKEN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ex_valid,
  input  logic       ex_set_flags,
  input  logic       ex_zero,
  input  logic       ex_negative,
  input  logic       ex_overflow,
  input  logic       ex_carry,
  input  logic       pipe_stall,
  input  logic       flush,
  input  logic       br_valid,
  input  logic [1:0] br_kind,
  input  logic [3:0] br_cond,
  input  logic       br_reg_zero,
  output logic [3:0] flags_q,
  output logic       stall_o,
  output logic       br_resolved_q,
  output logic       br_taken_q
);

  // Branch kind encodings
  localparam logic [1:0] KIND_COND = 2'b00;
  localparam logic [1:0] KIND_CBZ  = 2'b01;
  localparam logic [1:0] KIND_CBNZ = 2'b10;
  localparam logic [1:0] KIND_B    = 2'b11;

  typedef enum logic {
    IDLE,
    WAIT_FLAGS
  } state_t;

  state_t     state_q;
  logic [3:0] pend_cond_q;  // condition of the B.cond parked during a stall

  logic       ex_flag_write;
  logic [3:0] ex_flags;
  logic [3:0] eff_flags;
  logic       decision;

  assign ex_flag_write = ex_valid & ex_set_flags;
  assign ex_flags      = {ex_negative, ex_zero, ex_carry, ex_overflow};

  // ---------------------------------------------------------------------------
  // Condition evaluation on an {N,Z,C,V} vector
  // ---------------------------------------------------------------------------
  function automatic logic cond_holds(input logic [3:0] cond,
                                      input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: cond_holds = z;                 // EQ
      4'b0001: cond_holds = !z;                // NE
      4'b0010: cond_holds = c;                 // HS
      4'b0011: cond_holds = !c;                // LO
      4'b0100: cond_holds = n;                 // MI
      4'b0101: cond_holds = !n;                // PL
      4'b0110: cond_holds = v;                 // VS
      4'b0111: cond_holds = !v;                // VC
      4'b1000: cond_holds = c && !z;           // HI
      4'b1001: cond_holds = !c || z;           // LS
      4'b1010: cond_holds = (n == v);          // GE
      4'b1011: cond_holds = (n != v);          // LT
      4'b1100: cond_holds = !z && (n == v);    // GT
      4'b1101: cond_holds = z || (n != v);     // LE
      4'b1110: cond_holds = 1'b1;              // AL
      default: cond_holds = AL_TAKEN;          // 1111
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Effective flags seen by an ID branch in this cycle
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    eff_flags = flags_q;
    if (BYPASS && ex_flag_write) begin
      eff_flags = ex_flags;
    end
  end

  // Decision for a branch accepted directly from IDLE
  always_comb begin
    decision = 1'b0;
    case (br_kind)
      KIND_COND: decision = cond_holds(br_cond, eff_flags);
      KIND_CBZ:  decision = br_reg_zero;
      KIND_CBNZ: decision = !br_reg_zero;
      KIND_B:    decision = 1'b1;
      default:   decision = 1'b0;
    endcase
  end

  // Flag hazard: only a B.cond can depend on the EX flag write, and only
  // the stalling build raises the hold. A flushed branch needs no hold.
  assign stall_o = !BYPASS && (state_q == IDLE) && br_valid
                   && (br_kind == KIND_COND) && ex_flag_write && !flush;

  // ---------------------------------------------------------------------------
  // Architectural flag register
  // ---------------------------------------------------------------------------
  // The EX instruction is older than the one in ID, so flush does not block
  // the write. Only the external freeze holds it.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (ex_flag_write && !pipe_stall) begin
      flags_q <= ex_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Resolution FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pend_cond_q   <= 4'b0000;
      br_resolved_q <= 1'b0;
      br_taken_q    <= 1'b0;
    end else if (!pipe_stall) begin
      // Resolution is a pulse. br_taken_q keeps its last value.
      br_resolved_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (stall_o) begin
            // Park the branch. Its flags land in flags_q at this same edge.
            pend_cond_q <= br_cond;
            state_q     <= WAIT_FLAGS;
          end else if (br_valid && !flush) begin
            br_resolved_q <= 1'b1;
            br_taken_q    <= decision;
          end
        end
        WAIT_FLAGS: begin
          // ID is still holding the stalled branch, so it is resolved here
          // and not accepted a second time.
          state_q <= IDLE;
          if (!flush) begin
            br_resolved_q <= 1'b1;
            br_taken_q    <= cond_holds(pend_cond_q, flags_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_branch_unit
//
// Two instances share one set of inputs:
//   u_byp : BYPASS=1, AL_TAKEN=1
//   u_stl : BYPASS=0, AL_TAKEN=0
// Expected values are written by hand in each scenario task.
// -----------------------------------------------------------------------------
module tb_flag_branch_unit;

  logic       clk;
  logic       reset;
  logic       ex_valid, ex_set_flags, ex_zero, ex_negative, ex_overflow, ex_carry;
  logic       pipe_stall, flush;
  logic       br_valid;
  logic [1:0] br_kind;
  logic [3:0] br_cond;
  logic       br_reg_zero;

  logic [3:0] b_flags, s_flags;
  logic       b_stall, s_stall;
  logic       b_res, s_res;
  logic       b_taken, s_taken;

  int errors = 0;
  int checks = 0;

  logic [5:0] cond_tbl [16];

  flag_branch_unit #(.BYPASS(1'b1), .AL_TAKEN(1'b1)) u_byp (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_zero(ex_zero),
    .ex_negative(ex_negative), .ex_overflow(ex_overflow), .ex_carry(ex_carry),
    .pipe_stall(pipe_stall), .flush(flush),
    .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond),
    .br_reg_zero(br_reg_zero),
    .flags_q(b_flags), .stall_o(b_stall),
    .br_resolved_q(b_res), .br_taken_q(b_taken)
  );

  flag_branch_unit #(.BYPASS(1'b0), .AL_TAKEN(1'b0)) u_stl (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_zero(ex_zero),
    .ex_negative(ex_negative), .ex_overflow(ex_overflow), .ex_carry(ex_carry),
    .pipe_stall(pipe_stall), .flush(flush),
    .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond),
    .br_reg_zero(br_reg_zero),
    .flags_q(s_flags), .stall_o(s_stall),
    .br_resolved_q(s_res), .br_taken_q(s_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_set_flags = 0; ex_zero = 0; ex_negative = 0;
    ex_overflow = 0; ex_carry = 0; pipe_stall = 0; flush = 0;
    br_valid = 0; br_kind = 2'b00; br_cond = 4'b0000; br_reg_zero = 0;
  endtask

  task automatic ex_write(input logic n, input logic z, input logic c,
                          input logic v);
    ex_valid = 1; ex_set_flags = 1;
    ex_negative = n; ex_zero = z; ex_carry = c; ex_overflow = v;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_set_flags = 0;
    ex_negative = 0; ex_zero = 0; ex_carry = 0; ex_overflow = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // Every other input is active during reset: reset must win.
    clear_inputs();
    ex_write(1, 1, 1, 1);
    br_valid = 1; br_kind = 2'b11;
    reset = 1;
    step();
    step();
    reset = 0;
    clear_inputs();
    #1;
    checks++;
    if ({b_flags, b_stall, b_res, b_taken} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_byp: got %b expected %b",
               {b_flags, b_stall, b_res, b_taken}, 7'b0000_000);
    end
    checks++;
    if ({s_flags, s_stall, s_res, s_taken} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_stl: got %b expected %b",
               {s_flags, s_stall, s_res, s_taken}, 7'b0000_000);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flag_write();
    do_reset();
    ex_write(0, 1, 1, 0);   // SUBS with result 0
    step();
    ex_idle();
    checks++;
    if ({b_flags, b_res, b_taken} !== 6'b0110_00) begin
      errors++;
      $display("FAIL flag_write_byp: got %b expected %b",
               {b_flags, b_res, b_taken}, 6'b0110_00);
    end
    checks++;
    if ({s_flags, s_stall, s_res, s_taken} !== 7'b0110_000) begin
      errors++;
      $display("FAIL flag_write_stl: got %b expected %b",
               {s_flags, s_stall, s_res, s_taken}, 7'b0110_000);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bypass();
    do_reset();
    ex_write(1, 0, 0, 0);   // ADDS sets N=1, V=0
    br_valid = 1; br_kind = 2'b00; br_cond = 4'b1011;   // B.LT
    #1;
    checks++;
    if (b_stall !== 1'b0) begin
      errors++;
      $display("FAIL bypass_no_stall: got %b expected 0", b_stall);
    end
    step();
    clear_inputs();
    checks++;
    if ({b_flags, b_res, b_taken} !== 6'b1000_11) begin
      errors++;
      $display("FAIL bypass_resolve: got %b expected %b",
               {b_flags, b_res, b_taken}, 6'b1000_11);
    end
    step();
    checks++;
    if ({b_res, b_taken} !== 2'b01) begin
      errors++;
      $display("FAIL bypass_pulse_end: got %b expected 01", {b_res, b_taken});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall();
    do_reset();
    ex_write(1, 0, 0, 0);
    br_valid = 1; br_kind = 2'b00; br_cond = 4'b1011;
    #1;
    checks++;
    if (s_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_raise: got %b expected 1", s_stall);
    end
    step();
    ex_idle();              // ID keeps presenting the held branch
    #1;
    checks++;
    if ({s_flags, s_stall, s_res} !== 6'b1000_00) begin
      errors++;
      $display("FAIL stall_wait: got %b expected %b",
               {s_flags, s_stall, s_res}, 6'b1000_00);
    end
    step();
    clear_inputs();
    checks++;
    if ({s_res, s_taken} !== 2'b11) begin
      errors++;
      $display("FAIL stall_resolve: got %b expected 11", {s_res, s_taken});
    end
    step();
    checks++;
    if (s_res !== 1'b0) begin
      errors++;
      $display("FAIL stall_pulse_end: got %b expected 0", s_res);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_cb_kinds();
    do_reset();
    ex_write(0, 1, 0, 0);
    br_valid = 1; br_kind = 2'b10; br_reg_zero = 0;    // CBNZ, reg != 0
    #1;
    checks++;
    if ({b_stall, s_stall} !== 2'b00) begin
      errors++;
      $display("FAIL cbnz_no_stall: got %b expected 00", {b_stall, s_stall});
    end
    step();
    br_kind = 2'b01;                                    // CBZ, reg != 0
    #1;
    checks++;
    if ({b_res, b_taken, s_res, s_taken} !== 4'b1111) begin
      errors++;
      $display("FAIL cbnz_taken: got %b expected 1111",
               {b_res, b_taken, s_res, s_taken});
    end
    checks++;
    if (s_stall !== 1'b0) begin
      errors++;
      $display("FAIL cbz_no_stall: got %b expected 0", s_stall);
    end
    step();
    br_kind = 2'b11;                                    // B
    checks++;
    if ({b_res, b_taken, s_res, s_taken} !== 4'b1010) begin
      errors++;
      $display("FAIL cbz_not_taken: got %b expected 1010",
               {b_res, b_taken, s_res, s_taken});
    end
    step();
    clear_inputs();
    checks++;
    if ({b_res, b_taken, s_res, s_taken} !== 4'b1111) begin
      errors++;
      $display("FAIL b_taken: got %b expected 1111",
               {b_res, b_taken, s_res, s_taken});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Flags Z=1, C=1 (N=V=0). Back-to-back B.cond every cycle.
  // Entry: {cond, expected taken for u_byp, expected taken for u_stl}
  task automatic test_conditions();
    cond_tbl = '{
      {4'b1100, 1'b0, 1'b0},   // GT
      {4'b1000, 1'b0, 1'b0},   // HI
      {4'b1001, 1'b1, 1'b1},   // LS
      {4'b1010, 1'b1, 1'b1},   // GE
      {4'b0000, 1'b1, 1'b1},   // EQ
      {4'b0001, 1'b0, 1'b0},   // NE
      {4'b0010, 1'b1, 1'b1},   // HS
      {4'b0011, 1'b0, 1'b0},   // LO
      {4'b0100, 1'b0, 1'b0},   // MI
      {4'b0101, 1'b1, 1'b1},   // PL
      {4'b0110, 1'b0, 1'b0},   // VS
      {4'b0111, 1'b1, 1'b1},   // VC
      {4'b1011, 1'b0, 1'b0},   // LT
      {4'b1101, 1'b1, 1'b1},   // LE
      {4'b1110, 1'b1, 1'b1},   // AL
      {4'b1111, 1'b1, 1'b0}    // 1111: taken only when AL_TAKEN=1
    };
    do_reset();
    ex_write(0, 1, 1, 0);
    step();
    ex_idle();
    br_valid = 1; br_kind = 2'b00;
    for (int i = 0; i < 16; i++) begin
      br_cond = cond_tbl[i][5:2];
      step();
      checks++;
      if ({b_res, b_taken, s_res, s_taken} !==
          {1'b1, cond_tbl[i][1], 1'b1, cond_tbl[i][0]}) begin
        errors++;
        $display("FAIL cond_%b: got %b expected %b", cond_tbl[i][5:2],
                 {b_res, b_taken, s_res, s_taken},
                 {1'b1, cond_tbl[i][1], 1'b1, cond_tbl[i][0]});
      end
    end
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    do_reset();
    ex_write(1, 0, 0, 0);
    br_valid = 1; br_kind = 2'b00; br_cond = 4'b0000; flush = 1;
    #1;
    checks++;
    if (s_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_stall: got %b expected 0", s_stall);
    end
    step();
    clear_inputs();
    checks++;
    if ({b_flags, b_res, s_flags, s_res} !== 10'b1000_0_1000_0) begin
      errors++;
      $display("FAIL flush_id: got %b expected %b",
               {b_flags, b_res, s_flags, s_res}, 10'b1000_0_1000_0);
    end

    // Flush while a branch is parked in WAIT_FLAGS
    ex_write(1, 0, 0, 0);
    br_valid = 1; br_kind = 2'b00; br_cond = 4'b1011;
    step();
    ex_idle();
    flush = 1;
    step();
    checks++;
    if (s_res !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait: got %b expected 0", s_res);
    end
    flush = 0; br_kind = 2'b11;    // FSM must be back in IDLE: 1-cycle latency
    step();
    clear_inputs();
    checks++;
    if ({s_res, s_taken} !== 2'b11) begin
      errors++;
      $display("FAIL flush_wait_recover: got %b expected 11", {s_res, s_taken});
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_pipe_stall();
    do_reset();
    br_valid = 1; br_kind = 2'b11;
    step();
    // Freeze with a flag write and a not-taken CBNZ pending
    pipe_stall = 1;
    ex_write(0, 1, 0, 0);
    br_kind = 2'b10; br_reg_zero = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({b_flags, b_res, b_taken, s_flags, s_res, s_taken} !==
          12'b0000_11_0000_11) begin
        errors++;
        $display("FAIL freeze_%0d: got %b expected %b", i,
                 {b_flags, b_res, b_taken, s_flags, s_res, s_taken},
                 12'b0000_11_0000_11);
      end
    end
    pipe_stall = 0;
    br_valid = 0;
    step();
    clear_inputs();
    checks++;
    if ({b_flags, b_res, b_taken, s_flags, s_res, s_taken} !==
        12'b0100_01_0100_01) begin
      errors++;
      $display("FAIL freeze_release: got %b expected %b",
               {b_flags, b_res, b_taken, s_flags, s_res, s_taken},
               12'b0100_01_0100_01);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_in_wait();
    do_reset();
    ex_write(1, 0, 0, 0);
    br_valid = 1; br_kind = 2'b00; br_cond = 4'b1011;
    step();                 // u_stl now in WAIT_FLAGS
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    checks++;
    if ({s_flags, s_res} !== 5'b0000_0) begin
      errors++;
      $display("FAIL reset_wait: got %b expected 00000", {s_flags, s_res});
    end
    step();
    checks++;
    if (s_res !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_dropped: got %b expected 0", s_res);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_flag_write();
    test_bypass();
    test_stall();
    test_cb_kinds();
    test_conditions();
    test_flush();
    test_pipe_stall();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumes the ALU flag outputs (Zero, Negative, Overflow, CarryOut) from the EX stage.
- Holds the architectural NZCV flag register, updated by flag-setting instructions.
- Resolves conditional branches issued from ID: B.cond, CBZ, CBNZ and unconditional B.
- Sits between the EX-stage ALU and the ID-stage branch/PC-select logic of the 5-stage pipeline. It produces a registered taken/not-taken decision and a hazard stall.

Parameters:
- BYPASS, 1: 1 = same-cycle forwarding of EX flag writes to the ID branch; 0 = stall one cycle instead.
- AL_TAKEN, 1: 1 = condition codes 1110/1111 resolve taken; 0 = treat 1111 as never.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  EX stage holds a live instruction
- ex_set_flags  input  1  EX instruction writes NZCV
- ex_zero  input  1  ALU Zero
- ex_negative  input  1  ALU Negative
- ex_overflow  input  1  ALU Overflow
- ex_carry  input  1  ALU CarryOut
- pipe_stall  input  1  external pipeline freeze; holds all state
- flush  input  1  kill the instruction in ID
- br_valid  input  1  ID holds a branch
- br_kind  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B
- br_cond  input  4  LEGv8 condition code, used when br_kind=00
- br_reg_zero  input  1  tested register equals zero (CBZ/CBNZ)
- flags_q  output  4  {N,Z,C,V} architectural flags
- stall_o  output  1  request ID/IF hold (flag hazard)
- br_resolved_q  output  1  one-cycle pulse: a branch was resolved
- br_taken_q  output  1  decision, valid while br_resolved_q=1

Behaviour:
- Reset (sync, active-high): flags_q=0000, br_resolved_q=0, br_taken_q=0, stall_o=0, FSM=IDLE. Reset has priority over every other input in the same edge.
- Flag write:
  - Condition: ex_valid & ex_set_flags & !pipe_stall at a rising edge.
  - Action: flags_q <= {ex_negative, ex_zero, ex_carry, ex_overflow}.
  - flush does not block it; the EX instruction is older than ID.
- Effective flags for evaluation:
  - If ex_valid & ex_set_flags and BYPASS=1: use the live ex_* values.
  - Otherwise: use flags_q.
- Conditions:
  - EQ 0000 Z; NE 0001 !Z; HS 0010 C; LO 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
  - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 taken; 1111 taken iff AL_TAKEN.
- Kinds:
  - CBZ taken = br_reg_zero; CBNZ = !br_reg_zero; B = always taken.
  - CBZ, CBZN and B never depend on flags and never stall.
- FSM states: IDLE, WAIT_FLAGS.
  - IDLE, BYPASS=0, br_valid & br_kind=00 & ex_valid & ex_set_flags & !flush: assert stall_o combinationally, go to WAIT_FLAGS, no resolution this cycle.
  - WAIT_FLAGS: stall_o=0; evaluate from flags_q (now updated); resolve; return to IDLE.
  - flush in WAIT_FLAGS: return to IDLE without resolving.
  - With BYPASS=1 the FSM never leaves IDLE.
- Resolution timing:
  - An accepted branch at edge t gives br_resolved_q=1 and br_taken_q=decision for the cycle after t (1-cycle latency).
  - br_resolved_q returns to 0 next edge unless another branch is accepted.
  - br_taken_q holds its last value when not resolved.
- Acceptance: br_valid & !flush & !pipe_stall & !stall_o.
- Freeze and flush:
  - pipe_stall=1 freezes flags_q, FSM and both br_*_q outputs; br_resolved_q is held, not re-pulsed by the bench.
  - flush with br_valid: no resolution, br_resolved_q=0 next cycle.
- Back-to-back branches resolve on consecutive cycles.
- Reset mid-WAIT_FLAGS: the pending branch is dropped.

Test Plan:
- Reset, then SUBS result 0 (ex_zero=1, ex_carry=1, set_flags=1) -> next cycle flags_q=0100+0010=0110 (Z,C); other outputs 0.
- BYPASS=1: EX ADDS sets N=1,V=0 while ID holds B.cond LT (1011) -> stall_o=0; next cycle br_resolved_q=1, br_taken_q=1; flags_q=1000.
- BYPASS=0, same stimulus -> stall_o=1 for one cycle; resolution appears two cycles after branch presentation, br_taken_q=1.
- CBNZ with br_reg_zero=0 while EX sets flags -> no stall, br_taken_q=1 next cycle; CBZ with br_reg_zero=0 -> br_taken_q=0.
- Flags Z=1,C=1: GT -> 0, HI -> 0, LS -> 1, GE (N=V=0) -> 1, 1111 with AL_TAKEN=0 -> 0.
- Flush with br_valid plus EX flag write -> br_resolved_q=0 but flags_q updated. Also pipe_stall=1 for 3 cycles during a flag write -> flags_q unchanged until release.
